// File: rtl/rf_context_sequencer.sv
// rf_context_sequencer: hardware context save/restore engine for interrupt entry/exit.
// On irq entry it streams the registers selected by SaveMask from register file
// port A to a stack frame below sp, then pulses ra_set_o so the register file
// loads the return magic into ra. On irq exit it streams the same frame back
// into the register file through write port W1. While idle, core accesses pass
// straight through to the register file.
//
// Ports:
//   clk_i, rst_ni                   clock, synchronous active-low reset
//   irq_entry_i, irq_exit_i, sp_i   start pulses and stack pointer sampled on start
//   busy_o, done_o                  core stall, 1-cycle completion pulse
//   core_raddr_a_i, core_waddr_i,
//   core_wdata_i, core_we_i         core register file accesses (passed through when idle)
//   rf_raddr_a_o, rf_rdata_a_i,
//   rf_waddr_o, rf_wdata_o, rf_we_o register file read port A and write port W1
//   ra_set_o                        1-cycle pulse: register file loads magic into ra
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_rdata_i,
//   mem_ack_i                       word memory port, request held until ack
module rf_context_sequencer #(
    parameter logic [31:0] SaveMask = 32'hF003_FCE2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        irq_entry_i,
    input  logic        irq_exit_i,
    input  logic [31:0] sp_i,
    output logic        busy_o,
    output logic        done_o,
    input  logic [4:0]  core_raddr_a_i,
    input  logic [4:0]  core_waddr_i,
    input  logic [31:0] core_wdata_i,
    input  logic        core_we_i,
    output logic [4:0]  rf_raddr_a_o,
    input  logic [31:0] rf_rdata_a_i,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        rf_we_o,
    output logic        ra_set_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    // Number of saved registers; x0 is never saved.
    function automatic int unsigned count_saved(input logic [31:0] mask);
        int unsigned n;
        n = 0;
        for (int unsigned i = 1; i < 32; i++) begin
            if (mask[i]) n++;
        end
        return n;
    endfunction

    localparam int unsigned NumSaved   = count_saved(SaveMask);
    localparam int unsigned KW         = (NumSaved < 1) ? 1 : $clog2(NumSaved + 1);
    localparam logic [31:0] FrameBytes = 32'(4 * NumSaved);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        SET_RA  = 2'd2,
        RESTORE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     base_q, base_d;
    logic [KW-1:0]   k_q, k_d;
    logic            pending_q, pending_d;

    logic [4:0]      cur_reg;
    logic [31:0]     frame_addr;
    logic            last_k;
    logic            start_save;

    // Register index of the k-th set bit of SaveMask (ascending).
    function automatic logic [4:0] reg_of(input logic [KW-1:0] idx);
        int unsigned cnt;
        logic [4:0]  r;
        cnt = 0;
        r   = '0;
        for (int unsigned i = 1; i < 32; i++) begin
            if (SaveMask[i]) begin
                if (cnt == 32'(idx)) r = 5'(i);
                cnt++;
            end
        end
        return r;
    endfunction

    assign cur_reg    = reg_of(k_q);
    assign frame_addr = base_q + (32'(k_q) << 2);
    assign last_k     = (k_q == KW'(NumSaved - 1));

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            base_q    <= '0;
            k_q       <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            k_q       <= k_d;
            pending_q <= pending_d;
        end
    end

    // Next-state and port muxing.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        k_d          = k_q;
        pending_d    = pending_q;
        start_save   = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        ra_set_o     = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = frame_addr;
        mem_wdata_o  = '0;
        rf_raddr_a_o = cur_reg;
        rf_waddr_o   = cur_reg;
        rf_wdata_o   = mem_rdata_i;
        rf_we_o      = 1'b0;

        unique case (state_q)
            IDLE: begin
                rf_raddr_a_o = core_raddr_a_i;
                rf_waddr_o   = core_waddr_i;
                rf_wdata_o   = core_wdata_i;
                rf_we_o      = core_we_i;
                // Entry has priority over a simultaneous exit.
                if (irq_entry_i || pending_q) begin
                    start_save = 1'b1;
                end else if (irq_exit_i) begin
                    base_d  = sp_i;
                    k_d     = '0;
                    state_d = RESTORE;
                end
            end
            SAVE: begin
                busy_o      = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_wdata_o = rf_rdata_a_i;
                if (irq_entry_i) pending_d = 1'b1;
                if (mem_ack_i) begin
                    k_d = k_q + KW'(1);
                    if (last_k) state_d = SET_RA;
                end
            end
            SET_RA: begin
                busy_o   = 1'b1;
                ra_set_o = 1'b1;
                done_o   = 1'b1;
                state_d  = IDLE;
                if (irq_entry_i || pending_q) start_save = 1'b1;
            end
            RESTORE: begin
                busy_o    = 1'b1;
                mem_req_o = 1'b1;
                rf_we_o   = mem_ack_i;
                if (irq_entry_i) pending_d = 1'b1;
                if (mem_ack_i) begin
                    k_d = k_q + KW'(1);
                    if (last_k) begin
                        done_o  = 1'b1;
                        state_d = IDLE;
                        if (irq_entry_i || pending_q) start_save = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A queued or fresh entry launches the save directly, sampling sp_i now.
        if (start_save) begin
            base_d    = sp_i - FrameBytes;
            k_d       = '0;
            pending_d = 1'b0;
            state_d   = SAVE;
        end
    end

endmodule

// File: tb/tb_rf_context_sequencer.sv
// Scoreboarded bench for rf_context_sequencer with a behavioural register file
// and a word memory with programmable ack latency.
module tb_rf_context_sequencer;

    localparam logic [31:0] MAGIC = 32'hFFFF_FFF0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mtx_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } rtx_t;

    logic        clk;
    logic        rst_ni;
    logic        irq_entry_i, irq_exit_i;
    logic [31:0] sp_i;
    logic        busy_o, done_o;
    logic [4:0]  core_raddr_a_i, core_waddr_i;
    logic [31:0] core_wdata_i;
    logic        core_we_i;
    logic [4:0]  rf_raddr_a_o, rf_waddr_o;
    logic [31:0] rf_rdata_a_i, rf_wdata_o;
    logic        rf_we_o, ra_set_o;
    logic        mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    rf_context_sequencer dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .irq_entry_i    (irq_entry_i),
        .irq_exit_i     (irq_exit_i),
        .sp_i           (sp_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .core_raddr_a_i (core_raddr_a_i),
        .core_waddr_i   (core_waddr_i),
        .core_wdata_i   (core_wdata_i),
        .core_we_i      (core_we_i),
        .rf_raddr_a_o   (rf_raddr_a_o),
        .rf_rdata_a_i   (rf_rdata_a_i),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_o     (rf_wdata_o),
        .rf_we_o        (rf_we_o),
        .ra_set_o       (ra_set_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .mem_ack_i      (mem_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file.
    logic [31:0] rf [32];
    logic        rf_init;
    assign rf_rdata_a_i = (rf_raddr_a_o == 5'd0) ? 32'h0 : rf[rf_raddr_a_o];

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'(i) * 32'h0101_0101;
        end else begin
            if (rf_we_o && rf_waddr_o != 5'd0) rf[rf_waddr_o] <= rf_wdata_o;
            if (ra_set_o) rf[1] <= MAGIC;
        end
    end

    // Word memory, 4 KiB window, ack after ack_lat wait cycles.
    logic [31:0] mem [1024];
    int          ack_lat;
    int          wcnt;
    logic        pre_en;
    logic [31:0] pre_base, pre_pat;
    assign mem_ack_i   = mem_req_o && (wcnt >= ack_lat);
    assign mem_rdata_i = mem[mem_addr_o[11:2]];

    always @(posedge clk) begin
        if (pre_en) begin
            for (int k = 0; k < 16; k++) mem[10'((pre_base >> 2) + 32'(k))] <= pre_pat | 32'(k);
        end else if (mem_req_o && mem_ack_i && mem_we_o) begin
            mem[mem_addr_o[11:2]] <= mem_wdata_o;
        end
        if (mem_req_o && !mem_ack_i) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    // Bench model state and scoreboard.
    int          regs [16] = '{1, 5, 6, 7, 10, 11, 12, 13, 14, 15, 16, 17, 28, 29, 30, 31};
    logic [31:0] exp_rf [32];
    mtx_t        mq [$];
    rtx_t        rq [$];
    int          n_tests, n_fails;
    int          ra_cnt;
    int          cyc;
    int          ra_before;
    mtx_t        mt_m;
    rtx_t        rt_m;
    logic        hold_v;
    logic [31:0] hold_addr, hold_wdata;
    logic        hold_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_save(input logic [31:0] sp, input int n);
        for (int k = 0; k < n; k++)
            mq.push_back('{1'b1, sp - 32'd64 + 32'(4 * k), exp_rf[regs[k]]});
    endtask

    task automatic push_restore(input logic [31:0] sp, input logic [31:0] pat);
        for (int k = 0; k < 16; k++) begin
            mq.push_back('{1'b0, sp + 32'(4 * k), 32'h0});
            rq.push_back('{5'(regs[k]), pat | 32'(k)});
            exp_rf[regs[k]] = pat | 32'(k);
        end
    endtask

    task automatic preload(input logic [31:0] base, input logic [31:0] pat);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_base = base; pre_pat = pat;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // Returns one ns into the first busy cycle.
    task automatic start_op(input logic ent, input logic ext, input logic [31:0] sp);
        @(posedge clk); #1;
        irq_entry_i = ent; irq_exit_i = ext; sp_i = sp;
        @(posedge clk); #1;
        irq_entry_i = 1'b0; irq_exit_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!done_o && c < budget);
        if (!done_o) chk("done_timeout", 32'(done_o), 32'd1);
    endtask

    initial begin
        n_tests = 0; n_fails = 0; ra_cnt = 0; hold_v = 1'b0;
        hold_addr = '0; hold_wdata = '0; hold_we = 1'b0;
        rst_ni = 1'b0; irq_entry_i = 1'b0; irq_exit_i = 1'b0; sp_i = '0;
        core_raddr_a_i = '0; core_waddr_i = '0; core_wdata_i = '0; core_we_i = 1'b0;
        ack_lat = 0; pre_en = 1'b0; pre_base = '0; pre_pat = '0; rf_init = 1'b1;
        for (int i = 0; i < 32; i++) exp_rf[i] = 32'(i) * 32'h0101_0101;

        // Monitor: pops the scoreboard on every memory handshake and restore write.
        fork
            forever begin
                @(negedge clk);
                if (mem_req_o && mem_ack_i) begin
                    if (hold_v) begin
                        chk("stable_addr", mem_addr_o, hold_addr);
                        chk("stable_we", 32'(mem_we_o), 32'(hold_we));
                        chk("stable_wdata", mem_wdata_o, hold_wdata);
                    end
                    if (mq.size() == 0) begin
                        chk("mem_unexpected", 32'(mq.size()), 32'd1);
                    end else begin
                        mt_m = mq.pop_front();
                        chk("mem_we", 32'(mem_we_o), 32'(mt_m.we));
                        chk("mem_addr", mem_addr_o, mt_m.addr);
                        if (mt_m.we) chk("mem_wdata", mem_wdata_o, mt_m.data);
                    end
                    hold_v = 1'b0;
                end else if (mem_req_o) begin
                    if (hold_v) begin
                        chk("stable_addr", mem_addr_o, hold_addr);
                        chk("stable_we", 32'(mem_we_o), 32'(hold_we));
                        chk("stable_wdata", mem_wdata_o, hold_wdata);
                    end
                    hold_v = 1'b1; hold_addr = mem_addr_o;
                    hold_we = mem_we_o; hold_wdata = mem_wdata_o;
                end else begin
                    hold_v = 1'b0;
                end
                if (busy_o && rf_we_o) begin
                    if (rq.size() == 0) begin
                        chk("rf_unexpected", 32'(rq.size()), 32'd1);
                    end else begin
                        rt_m = rq.pop_front();
                        chk("rf_waddr", 32'(rf_waddr_o), 32'(rt_m.addr));
                        chk("rf_wdata", rf_wdata_o, rt_m.data);
                    end
                end
                if (ra_set_o) ra_cnt++;
            end
        join_none

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_ra_set", 32'(ra_set_o), 32'd0);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_we", 32'(mem_we_o), 32'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1; rf_init = 1'b0;

        // Idle passthrough.
        core_we_i = 1'b1; core_waddr_i = 5'd7; core_wdata_i = 32'hDEAD_BEEF; core_raddr_a_i = 5'd3;
        @(negedge clk);
        chk("pass_we", 32'(rf_we_o), 32'd1);
        chk("pass_waddr", 32'(rf_waddr_o), 32'd7);
        chk("pass_wdata", rf_wdata_o, 32'hDEAD_BEEF);
        chk("pass_raddr", 32'(rf_raddr_a_o), 32'd3);
        exp_rf[7] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        core_we_i = 1'b0;

        // Save, zero-wait; core write attempts during busy must be ignored.
        push_save(32'h1000, 16);
        start_op(1'b1, 1'b0, 32'h1000);
        core_we_i = 1'b1; core_waddr_i = 5'd9; core_wdata_i = 32'h9999_9999;
        wait_done(40, cyc);
        core_we_i = 1'b0;
        chk("save_cycles", 32'(cyc), 32'd17);
        chk("save_ra_set", 32'(ra_set_o), 32'd1);
        exp_rf[1] = MAGIC;
        @(negedge clk);
        chk("save_idle_busy", 32'(busy_o), 32'd0);
        chk("save_ra_magic", rf[1], MAGIC);

        // Restore, zero-wait.
        preload(32'h0FC0, 32'hA000_0000);
        push_restore(32'h0FC0, 32'hA000_0000);
        start_op(1'b0, 1'b1, 32'h0FC0);
        wait_done(40, cyc);
        chk("rest_cycles", 32'(cyc), 32'd16);
        chk("rest_done_ack", 32'(mem_ack_i), 32'd1);
        chk("rest_done_ra_set", 32'(ra_set_o), 32'd0);
        @(negedge clk);
        chk("rest_idle_busy", 32'(busy_o), 32'd0);
        chk("rest_ra", rf[1], 32'hA000_0000);

        // Save with three wait states per request.
        ack_lat = 3;
        push_save(32'h1000, 16);
        start_op(1'b1, 1'b0, 32'h1000);
        wait_done(100, cyc);
        chk("wait_cycles", 32'(cyc), 32'd65);
        exp_rf[1] = MAGIC;
        @(negedge clk);
        ack_lat = 0;

        // Entry during restore at k=4 becomes pending; exit during save is dropped.
        preload(32'h0FC0, 32'hB000_0000);
        push_restore(32'h0FC0, 32'hB000_0000);
        push_save(32'h2000, 16);
        start_op(1'b0, 1'b1, 32'h0FC0);
        repeat (4) begin @(posedge clk); #1; end
        irq_entry_i = 1'b1; sp_i = 32'h2000;
        @(posedge clk); #1;
        irq_entry_i = 1'b0;
        wait_done(40, cyc);
        chk("pend_done_ack", 32'(mem_ack_i), 32'd1);
        @(negedge clk);
        chk("pend_busy", 32'(busy_o), 32'd1);
        chk("pend_req", 32'(mem_req_o), 32'd1);
        chk("pend_we", 32'(mem_we_o), 32'd1);
        chk("pend_addr", mem_addr_o, 32'h1FC0);
        chk("pend_no_done", 32'(done_o), 32'd0);
        @(posedge clk); #1;
        irq_exit_i = 1'b1;
        @(posedge clk); #1;
        irq_exit_i = 1'b0;
        wait_done(40, cyc);
        chk("pend_ra_set", 32'(ra_set_o), 32'd1);
        exp_rf[1] = MAGIC;
        repeat (3) begin
            @(negedge clk);
            chk("exit_dropped_busy", 32'(busy_o), 32'd0);
        end

        // Reset in the middle of a save at k=5.
        ack_lat = 2;
        push_save(32'h1000, 5);
        start_op(1'b1, 1'b0, 32'h1000);
        repeat (15) begin @(posedge clk); #1; end
        rst_ni = 1'b0;
        ra_before = ra_cnt;
        @(negedge clk);
        chk("rst_k5_addr", mem_addr_o, 32'h0FD4);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        ack_lat = 0;
        repeat (3) begin
            @(negedge clk);
            chk("rstmid_busy", 32'(busy_o), 32'd0);
            chk("rstmid_req", 32'(mem_req_o), 32'd0);
        end
        chk("rstmid_no_ra_set", 32'(ra_cnt), 32'(ra_before));
        push_save(32'h1000, 16);
        start_op(1'b1, 1'b0, 32'h1000);
        wait_done(40, cyc);
        chk("rstmid_restart_cycles", 32'(cyc), 32'd17);
        exp_rf[1] = MAGIC;

        // Entry and exit together: save only.
        push_save(32'h1000, 16);
        start_op(1'b1, 1'b1, 32'h1000);
        wait_done(40, cyc);
        chk("both_cycles", 32'(cyc), 32'd17);
        chk("both_ra_set", 32'(ra_set_o), 32'd1);
        exp_rf[1] = MAGIC;
        repeat (3) begin
            @(negedge clk);
            chk("both_idle_busy", 32'(busy_o), 32'd0);
        end

        // Final register file and scoreboard state.
        for (int i = 1; i < 32; i++) chk($sformatf("rf_x%0d", i), rf[i], exp_rf[i]);
        chk("mem_q_empty", 32'(mq.size()), 32'd0);
        chk("rf_q_empty", 32'(rq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
